r3_input_sequencer: RTL and testbench

R3_INPUT_SEQUENCER -- requirements
Module: r3_input_sequencer

---
 rtl/r3_input_sequencer.sv | 117 +++++++++++
 tb/tb_r3_input_sequencer.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/r3_input_sequencer.sv
// ============================================================================
// Module   : r3_input_sequencer
// Brief    : Byte queue presented one entry at a time on inR3_o each time the
//            program counter enters a trigger address. Optional error counter
//            enabled by macro R3_SEQ_ERR_CNT_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module r3_input_sequencer #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 6,
    parameter int DEPTH      = 8
) (
    input  logic                    clk,
    input  logic                    nReset,
    input  logic                    push_i,
    input  logic [DATA_WIDTH-1:0]   push_data_i,
    input  logic [ADDR_WIDTH-1:0]   PC_Addr_i,
    input  logic [ADDR_WIDTH-1:0]   trig_addr_i,
    output logic [DATA_WIDTH-1:0]   inR3_o,
    output logic                    full_o,
    output logic                    empty_o,
    output logic [$clog2(DEPTH):0]  count_o
`ifdef R3_SEQ_ERR_CNT_EN
    ,
    output logic [7:0]              err_cnt_o
`endif
);

    localparam int c_ptr_w = $clog2(DEPTH);
    localparam int c_cnt_w = c_ptr_w + 1;

    logic [DATA_WIDTH-1:0] mem_q [DEPTH];
    logic [c_ptr_w-1:0]    wr_ptr_q, wr_ptr_d;
    logic [c_ptr_w-1:0]    rd_ptr_q, rd_ptr_d;
    logic [c_cnt_w-1:0]    count_q, count_d;
    logic [DATA_WIDTH-1:0] inr3_q, inr3_d;
    logic [ADDR_WIDTH-1:0] pc_q;

    logic w_full, w_empty, w_advance, w_underflow, w_overflow, w_pop, w_push_ok;

    assign w_full  = (count_q == c_cnt_w'(DEPTH));
    assign w_empty = (count_q == '0);

    // Single pulse on entry into the trigger address only.
    assign w_advance   = (PC_Addr_i == trig_addr_i) && (pc_q != PC_Addr_i);
    assign w_underflow = w_advance && w_empty;
    assign w_pop       = w_advance && !w_underflow;
    // A pop in the same cycle frees the slot, so a full queue still accepts.
    assign w_overflow  = push_i && w_full && !w_pop;
    assign w_push_ok   = push_i && !w_overflow;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        inr3_d   = inr3_q;
        if (w_push_ok) begin
            wr_ptr_d = wr_ptr_q + c_ptr_w'(1);
        end
        if (w_pop) begin
            rd_ptr_d = rd_ptr_q + c_ptr_w'(1);
            inr3_d   = mem_q[rd_ptr_q];
        end
        case ({w_push_ok, w_pop})
            2'b10:   count_d = count_q + c_cnt_w'(1);
            2'b01:   count_d = count_q - c_cnt_w'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            inr3_q   <= '0;
            pc_q     <= '1;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
            inr3_q   <= inr3_d;
            pc_q     <= PC_Addr_i;
        end
    end

    // Storage is not reset; pointers and count define what is valid.
    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            mem_q[wr_ptr_q] <= push_data_i;
        end
    end

    assign inR3_o  = inr3_q;
    assign full_o  = w_full;
    assign empty_o = w_empty;
    assign count_o = count_q;

`ifdef R3_SEQ_ERR_CNT_EN
    logic [7:0] err_cnt_q;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            err_cnt_q <= '0;
        end else if ((w_overflow || w_underflow) && (err_cnt_q != 8'hFF)) begin
            err_cnt_q <= err_cnt_q + 8'd1;
        end
    end

    assign err_cnt_o = err_cnt_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_r3_input_sequencer.sv
// ============================================================================
// Module   : tb_r3_input_sequencer
// Brief    : Directed self-checking bench for r3_input_sequencer.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_r3_input_sequencer;

    logic       clk;
    logic       nReset;
    logic       push_i;
    logic [7:0] push_data_i;
    logic [5:0] PC_Addr_i;
    logic [5:0] trig_addr_i;
    logic [7:0] inR3_o;
    logic       full_o;
    logic       empty_o;
    logic [3:0] count_o;
`ifdef R3_SEQ_ERR_CNT_EN
    logic [7:0] err_cnt_o;
`endif

    int n_pass  = 0;
    int n_total = 0;

    r3_input_sequencer #(
        .DATA_WIDTH (8),
        .ADDR_WIDTH (6),
        .DEPTH      (8)
    ) dut (
        .clk         (clk),
        .nReset      (nReset),
        .push_i      (push_i),
        .push_data_i (push_data_i),
        .PC_Addr_i   (PC_Addr_i),
        .trig_addr_i (trig_addr_i),
        .inR3_o      (inR3_o),
        .full_o      (full_o),
        .empty_o     (empty_o),
        .count_o     (count_o)
`ifdef R3_SEQ_ERR_CNT_EN
        ,
        .err_cnt_o   (err_cnt_o)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        nReset    = 1'b0;
        push_i    = 1'b0;
        PC_Addr_i = 6'd0;
        #2;
        nReset    = 1'b1;
        tick();
    endtask

    // Leave the trigger address, then re-enter it: exactly one advance.
    task automatic adv();
        PC_Addr_i = 6'd0;
        tick();
        PC_Addr_i = 6'd3;
        tick();
    endtask

    task automatic push1(input logic [7:0] d);
        push_i      = 1'b1;
        push_data_i = d;
        tick();
        push_i      = 1'b0;
    endtask

    initial begin
        nReset      = 1'b0;
        push_i      = 1'b0;
        push_data_i = 8'h00;
        PC_Addr_i   = 6'd0;
        trig_addr_i = 6'd3;
        #22;
        chk("rst_count", 32'(count_o), 32'd0);
        chk("rst_inr3",  32'(inR3_o),  32'h00);
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full",  32'(full_o),  32'd0);
        nReset = 1'b1;
        tick();

        // Basic presentation and one-shot triggering
        push1(8'h55); push1(8'hF0); push1(8'hF0); push1(8'h0F); push1(8'hFF);
        chk("fill5_count", 32'(count_o), 32'd5);
        PC_Addr_i = 6'd1; tick();
        PC_Addr_i = 6'd2; tick();
        chk("pre_trig_inr3", 32'(inR3_o), 32'h00);
        PC_Addr_i = 6'd3; tick();
        chk("trig_inr3",  32'(inR3_o),  32'h55);
        chk("trig_count", 32'(count_o), 32'd4);
        for (int i = 0; i < 5; i++) tick();
        chk("hold_inr3",  32'(inR3_o),  32'h55);
        chk("hold_count", 32'(count_o), 32'd4);
        PC_Addr_i = 6'd4; tick();
        PC_Addr_i = 6'd3; tick();
        chk("reenter_inr3",  32'(inR3_o),  32'hF0);
        chk("reenter_count", 32'(count_o), 32'd3);
        adv(); chk("drain_a", 32'(inR3_o), 32'hF0);
        adv(); chk("drain_b", 32'(inR3_o), 32'h0F);
        adv(); chk("drain_c", 32'(inR3_o), 32'hFF);
        chk("drain_empty", 32'(empty_o), 32'd1);
        adv();
        chk("underflow_hold",  32'(inR3_o),  32'hFF);
        chk("underflow_count", 32'(count_o), 32'd0);

        // Overflow: ninth byte dropped
        do_reset();
        for (int i = 1; i <= 8; i++) push1(8'(i));
        chk("ovf_full",  32'(full_o),  32'd1);
        chk("ovf_count", 32'(count_o), 32'd8);
        push1(8'h09);
        chk("ovf_count_after", 32'(count_o), 32'd8);
`ifdef R3_SEQ_ERR_CNT_EN
        chk("ovf_err", 32'(err_cnt_o), 32'd1);
`endif
        for (int i = 1; i <= 8; i++) begin
            adv();
            chk("ovf_order", 32'(inR3_o), 32'(i));
        end
        chk("ovf_empty", 32'(empty_o), 32'd1);

        // Push and advance together on an empty queue: no bypass
        do_reset();
        push1(8'h3C);
        adv();
        chk("pe_seed", 32'(inR3_o), 32'h3C);
        PC_Addr_i   = 6'd0; tick();
        PC_Addr_i   = 6'd3;
        push_i      = 1'b1;
        push_data_i = 8'hA5;
        tick();
        push_i      = 1'b0;
        chk("pe_inr3",  32'(inR3_o),  32'h3C);
        chk("pe_count", 32'(count_o), 32'd1);
`ifdef R3_SEQ_ERR_CNT_EN
        chk("pe_err", 32'(err_cnt_o), 32'd1);
`endif
        adv();
        chk("pe_next", 32'(inR3_o), 32'hA5);

        // Push and advance together on a full queue
        do_reset();
        for (int i = 0; i < 8; i++) push1(8'h10 + 8'(i));
        PC_Addr_i   = 6'd0; tick();
        PC_Addr_i   = 6'd3;
        push_i      = 1'b1;
        push_data_i = 8'h77;
        tick();
        push_i      = 1'b0;
        chk("pf_count", 32'(count_o), 32'd8);
        chk("pf_inr3",  32'(inR3_o),  32'h10);
        for (int i = 1; i < 8; i++) begin
            adv();
            chk("pf_order", 32'(inR3_o), 32'h10 + 32'(i));
        end
        adv();
        chk("pf_last", 32'(inR3_o),  32'h77);
        chk("pf_zero", 32'(count_o), 32'd0);

        // Steady push/pop pairs wrapping the pointers several times
        push1(8'hC0);
        for (int i = 0; i < 20; i++) begin
            PC_Addr_i   = 6'd0; tick();
            PC_Addr_i   = 6'd3;
            push_i      = 1'b1;
            push_data_i = 8'hC1 + 8'(i);
            tick();
            push_i      = 1'b0;
            chk("wrap_val",   32'(inR3_o),  32'hC0 + 32'(i));
            chk("wrap_count", 32'(count_o), 32'd1);
        end

        // Asynchronous reset mid-stream
        do_reset();
        for (int i = 0; i < 6; i++) push1(8'h20 + 8'(i));
        adv();
        chk("ar_pre_count", 32'(count_o), 32'd5);
        chk("ar_pre_inr3",  32'(inR3_o),  32'h20);
        nReset = 1'b0;
        #1;
        chk("ar_count", 32'(count_o), 32'd0);
        chk("ar_inr3",  32'(inR3_o),  32'h00);
        chk("ar_empty", 32'(empty_o), 32'd1);
        chk("ar_full",  32'(full_o),  32'd0);
        #1;
        nReset = 1'b1;
        tick();

        // PC = trigger = 0 right after reset counts as an advance (underflow)
        trig_addr_i = 6'd0;
        nReset      = 1'b0;
        PC_Addr_i   = 6'd0;
        #2;
        nReset      = 1'b1;
        tick();
        chk("pc0_count", 32'(count_o), 32'd0);
        chk("pc0_inr3",  32'(inR3_o),  32'h00);
`ifdef R3_SEQ_ERR_CNT_EN
        chk("pc0_err", 32'(err_cnt_o), 32'd1);
        tick();
        chk("pc0_err_hold", 32'(err_cnt_o), 32'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

`default_nettype wire
